// File: rtl/cpu2core_irq_ctrl.sv
// Interrupt controller for the CPU core.
// Gathers NUM_IRQ request lines, applies per-source level/edge mode and an enable mask,
// and drives one registered irq plus the index of the lowest-numbered active source.
// The Avalon-MM slave matches the interval timer: 3-bit word address, 16-bit data,
// registered readdata and no waitstates.
module cpu2core_irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter logic [15:0] MODE_RESET = 16'h0000,
    parameter logic [15:0] MASK_RESET = 16'h0000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in_i,
    input  logic [2:0]         address_i,
    input  logic               chipselect_i,
    input  logic               write_n_i,
    input  logic [15:0]        writedata_i,
    output logic [15:0]        readdata_o,
    output logic               irq_o,
    output logic [3:0]         irq_vector_o
);

    // Register map word addresses.
    localparam logic [2:0] AddrPending = 3'd0;
    localparam logic [2:0] AddrMask    = 3'd1;
    localparam logic [2:0] AddrMode    = 3'd2;
    localparam logic [2:0] AddrActive  = 3'd3;
    localparam logic [2:0] AddrVector  = 3'd4;
    localparam logic [2:0] AddrSwset   = 3'd5;

    // Zero-extend a per-source vector to the 16-bit bus width.
    function automatic logic [15:0] widen(input logic [NUM_IRQ-1:0] v);
        logic [15:0] w;
        w = '0;
        w[NUM_IRQ-1:0] = v;
        return w;
    endfunction

    // State.
    logic [NUM_IRQ-1:0] pend_q, pend_d;  // edge latches; always 0 for level-mode sources
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic [NUM_IRQ-1:0] prev_q;          // irq_in from the previous cycle
    logic [15:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;
    logic [3:0]         vec_q, vec_d;

    // Decoded bus strobes.
    logic               wr_en;
    logic [NUM_IRQ-1:0] wdata_n;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] swset;
    logic [NUM_IRQ-1:0] mode_chg;

    // Derived status.
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] pend_view;
    logic [NUM_IRQ-1:0] active;
    logic               any_active;
    logic [3:0]         active_idx;

    // Bits of writedata above NUM_IRQ have no destination.
    logic unused_wdata;
    assign unused_wdata = ^writedata_i;

    assign wr_en   = chipselect_i & ~write_n_i;
    assign wdata_n = writedata_i[NUM_IRQ-1:0];

    // Per-register write strobes and the set of sources whose mode is about to flip.
    always_comb begin
        w1c      = '0;
        swset    = '0;
        mode_chg = '0;
        mask_d   = mask_q;
        mode_d   = mode_q;
        if (wr_en) begin
            unique case (address_i)
                AddrPending: w1c = wdata_n;
                AddrMask:    mask_d = wdata_n;
                AddrMode: begin
                    mode_d   = wdata_n;
                    mode_chg = mode_q ^ wdata_n;
                end
                AddrSwset:   swset = wdata_n;
                default: ;
            endcase
        end
    end

    assign rise = irq_in_i & ~prev_q;

    // Edge latch update: a rise or software set wins over a same-cycle W1C so no event is
    // lost; a mode change empties the latch; level-mode sources never latch.
    always_comb begin
        pend_d = ~mode_chg & mode_q & (rise | swset | (pend_q & ~w1c));
    end

    // PENDING as seen by software: latched for edge sources, live input for level sources.
    assign pend_view  = (pend_q & mode_q) | (irq_in_i & ~mode_q);
    assign active     = pend_view & mask_q;
    assign any_active = |active;

    // Lowest-index active source wins; 0 when nothing is active.
    always_comb begin
        active_idx = 4'd0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (active[i]) begin
                active_idx = 4'(i);
            end
        end
    end

    // Output register inputs: irq and vector are registered together.
    always_comb begin
        irq_d = any_active;
        vec_d = active_idx;
    end

    // Read mux, sampled every cycle regardless of chipselect.
    always_comb begin
        rdata_d = 16'h0000;
        unique case (address_i)
            AddrPending: rdata_d = widen(pend_view);
            AddrMask:    rdata_d = widen(mask_q);
            AddrMode:    rdata_d = widen(mode_q);
            AddrActive:  rdata_d = widen(active);
            AddrVector:  rdata_d = {any_active, 11'b0, active_idx};
            default:     rdata_d = 16'h0000;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            mask_q  <= MASK_RESET[NUM_IRQ-1:0];
            mode_q  <= MODE_RESET[NUM_IRQ-1:0];
            prev_q  <= '0;
            rdata_q <= 16'h0000;
            irq_q   <= 1'b0;
            vec_q   <= 4'd0;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
            prev_q  <= irq_in_i;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
        end
    end

    assign readdata_o   = rdata_q;
    assign irq_o        = irq_q;
    assign irq_vector_o = vec_q;

endmodule
